ps2_kbd_rx: RTL and testbench

- PS/2 keyboard receiver: deserialises device-clocked 11-bit frames into scan-code bytes and buffers them in a small FIFO.
- Sits directly upstream of the MuxKey-based scan-code-to-ASCII/segment lookup, which consumes one byte per valid/ready handshake.
- Scan codes pass through raw; make/break (0xF0) interpretation belongs downstream.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_kbd_rx_sync_fifo.sv | 49 ++++
 rtl/ps2_kbd_rx.sv | 129 ++++++++++++
 tb/tb_ps2_kbd_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame layout, well-known scan codes and
// the odd-parity check used on every received frame.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Frame as it sits after LSB-first shifting: start bit lands in bit 0.
    typedef struct packed {
        logic       stop;
        logic [0:0] parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{p, d};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra MSB so
// full and empty are told apart without a separate count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd      = i_rd_en && !o_empty;
    // A write into a full FIFO is fine when the head leaves in the same cycle.
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; wrap is natural through the extra MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since reads are qualified by !o_empty.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the device clock/data pins, shifts in
// 11-bit frames on falling edges, checks them and queues good bytes.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_overflow,
    output logic       o_frame_err,
    input  logic       i_clr_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_bit;
    logic [3:0]             r_bit_cnt;
    logic [FRAME_BITS-2:0]  r_shift;
    logic [TW-1:0]          r_to_cnt;
    logic                   w_timeout;
    ps2_frame_t             w_frame;
    logic                   w_last;
    logic                   w_frame_ok;
    logic                   w_good;
    logic                   w_bad;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [7:0]             w_rd_data;

    // Reset asserts immediately and releases two clocks later, in step with clk.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Pin synchronisers plus one delayed copy of the clock for edge detection.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit  = r_dat_sync[SYNC_STAGES-1];

    // The stop bit is checked straight off the synchroniser, not after shifting.
    assign w_frame    = {w_bit, r_shift};
    assign w_last     = w_fall && (r_bit_cnt == 4'(FRAME_BITS - 1));
    assign w_frame_ok = !w_frame.start && w_frame.stop &&
                        odd_parity_ok(w_frame.data, w_frame.parity[0]);
    assign w_good     = w_last && w_frame_ok;
    assign w_bad      = w_last && !w_frame_ok;
    assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall &&
                        (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Bit counter and LSB-first shift register; a stalled partial frame is dropped silently.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
        end else if (w_fall) begin
            r_shift   <= {w_bit, r_shift[FRAME_BITS-2:1]};
            r_bit_cnt <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
        end else if (w_timeout) begin
            r_bit_cnt <= 4'd0;
        end
    end

    // Idle-time counter between device clock edges, only while mid-frame.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n)                                      r_to_cnt <= '0;
        else if (w_fall || r_bit_cnt == 4'd0 || w_timeout) r_to_cnt <= '0;
        else                                               r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign o_valid = !w_empty;
    assign w_pop   = o_valid && i_ready;
    assign o_data  = o_valid ? w_rd_data : 8'h00;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (w_rst_n),
        .i_wr_en   (w_good),
        .i_wr_data (w_frame.data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Sticky error flags; a new event in the same cycle beats clr_err.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (w_good && w_full && !w_pop) o_overflow <= 1'b1;
            else if (i_clr_err)             o_overflow <= 1'b0;
            if (w_bad)                      o_frame_err <= 1'b1;
            else if (i_clr_err)             o_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed scenarios plus randomized frames, checked
// against a byte-queue model that is updated once per whole frame.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int SS    = 2;
    localparam int TO    = 4096;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_overflow;
    logic       o_frame_err;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2c),
        .i_ps2_data  (ps2d),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_overflow  (o_overflow),
        .o_frame_err (o_frame_err),
        .i_clr_err   (clr)
    );

    // Model state and counters, written only by the compare process.
    logic [7:0] q[$];
    bit         m_ovf, m_ferr;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Requests from stimulus to the compare process, each held for one cycle.
    bit         settled = 0, ev_frame = 0, ev_pop = 0, ev_rst = 0;
    logic [7:0] ev_byte = 8'h00;
    int         ev_kind = 0;
    bit         lit_on = 0, lit_den = 0;
    logic       lit_v = 0, lit_ovf = 0, lit_ferr = 0;
    logic [7:0] lit_d = 8'h00;
    string      lit_tag = "";

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Compare process: checks DUT against the model every falling clk edge.
    initial forever begin
        @(negedge clk);
        if (ev_rst) begin q.delete(); m_ovf = 0; m_ferr = 0; end
        if (lit_on) begin
            chk({lit_tag, ".valid"}, 8'(o_valid), 8'(lit_v));
            if (lit_den) chk({lit_tag, ".data"}, o_data, lit_d);
            chk({lit_tag, ".ovf"}, 8'(o_overflow), 8'(lit_ovf));
            chk({lit_tag, ".ferr"}, 8'(o_frame_err), 8'(lit_ferr));
        end
        if (settled) begin
            chk("model.valid", 8'(o_valid), 8'(q.size() != 0));
            if (q.size() != 0) chk("model.data", o_data, q[0]);
            chk("model.ovf", 8'(o_overflow), 8'(m_ovf));
            chk("model.ferr", 8'(o_frame_err), 8'(m_ferr));
        end
        if ((settled && ready && q.size() != 0) || ev_pop) void'(q.pop_front());
        if (settled && clr) begin m_ovf = 0; m_ferr = 0; end
        if (ev_frame) begin
            if (ev_kind == 0) begin
                if (q.size() < DEPTH) q.push_back(ev_byte);
                else                  m_ovf = 1;
            end else begin
                m_ferr = 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic v, input bit den, input logic [7:0] d,
                       input logic ovf, input logic ferr);
        lit_tag = tag; lit_v = v; lit_den = den; lit_d = d; lit_ovf = ovf; lit_ferr = ferr;
        lit_on = 1;
        @(negedge clk); #1;
        lit_on = 0;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                              input bit lat_pin, input bit pop_chk);
        logic [10:0] fr;
        settled = 0;
        fr[0]   = (kind == 2);
        fr[8:1] = b;
        fr[9]   = ~(^b) ^ (kind == 1);
        fr[10]  = (kind != 3);
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            cyc(HALF);
            ps2c = 1'b0;
            if (i == 10 && (lat_pin || pop_chk)) begin
                cyc(SS);
                if (pop_chk) begin ready = 1'b1; ev_pop = 1; end
                if (lat_pin) lit("lat.check", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
                else         begin @(negedge clk); #1; end
                @(posedge clk); #1;
                ready = 1'b0; ev_pop = 0;
                if (lat_pin) lit("lat.next", 1'b1, 1'b1, b, 1'b0, 1'b0);
                cyc(HALF - SS - 1);
            end else begin
                cyc(HALF);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cyc(HALF);
        if (nbits == 11) begin
            ev_byte = b; ev_kind = kind; ev_frame = 1;
            cyc(1);
            ev_frame = 0;
        end
        cyc(SS + 4);
        settled = 1;
    endtask

    task automatic drain(input int n);
        ready = 1'b1; cyc(n); ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; cyc(1); clr = 1'b0;
    endtask

    // Stimulus
    initial begin
        logic [7:0] b;
        int         k;
        cyc(3);
        lit("reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1);
        rst = 1'b1;
        cyc(SS + 4);
        settled = 1;

        // Good frame 0x1C with latency pinned to the check cycle.
        send_frame(8'h1C, 0, 11, 1'b1, 1'b0);
        lit("good1C", 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0);
        cyc(1);
        drain(1);

        // Parity, start and stop failures.
        send_frame(8'h1C, 1, 11, 1'b0, 1'b0);
        lit("badpar", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1);
        pulse_clr();
        lit("clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1);
        send_frame(8'h3C, 2, 11, 1'b0, 1'b0);
        send_frame(8'h3C, 3, 11, 1'b0, 1'b0);
        lit("badss", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1);
        pulse_clr();

        // Overflow: nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 1'b0, 1'b0);
        lit("ovf", 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        cyc(1);
        drain(DEPTH + 2);
        lit("ovf.empty", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1);
        pulse_clr();

        // Full FIFO with a pop in the check cycle of the ninth frame.
        for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 0, 11, 1'b0, 1'b0);
        send_frame(8'h19, 0, 11, 1'b0, 1'b1);
        lit("fullpop", 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1);
        drain(DEPTH - 1);
        lit("fullpop.last", 1'b1, 1'b1, 8'h19, 1'b0, 1'b0);
        cyc(1);
        drain(2);

        // Timeout recovery from a five-bit fragment.
        send_frame(8'h77, 0, 5, 1'b0, 1'b0);
        cyc(TO + 10);
        send_frame(PS2_BREAK, 0, 11, 1'b0, 1'b0);
        lit("timeout", 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        cyc(1);
        drain(2);

        // Reset mid-frame with two bytes buffered.
        send_frame(8'hA1, 0, 11, 1'b0, 1'b0);
        send_frame(8'hB2, 0, 11, 1'b0, 1'b0);
        send_frame(8'h33, 0, 6, 1'b0, 1'b0);
        settled = 0;
        rst = 1'b0; ev_rst = 1;
        lit("rst.async", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1);
        ev_rst = 0;
        cyc(3);
        rst = 1'b1;
        cyc(SS + 4);
        settled = 1;
        send_frame(8'h5A, 0, 11, 1'b0, 1'b0);
        lit("rst.5A", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1);
        drain(1);
        lit("rst.sole", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1);

        // Randomized frames with random drain windows and clears.
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            k = (k < 5) ? 0 : k - 4;
            case ($urandom_range(0, 3))
                0:       b = PS2_BREAK;
                1:       b = PS2_EXT;
                default: b = 8'($urandom);
            endcase
            send_frame(b, k, 11, 1'b0, 1'b0);
            for (int j = $urandom_range(0, 12); j > 0; j--) begin
                ready = ($urandom_range(0, 3) == 0);
                clr   = ($urandom_range(0, 15) == 0);
                cyc(1);
            end
            ready = 1'b0;
            clr   = 1'b0;
            cyc(1);
        end
        drain(DEPTH + 1);
        cyc(2);
        settled = 0;
        cyc(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
